// File: rtl/seq_div_pkg.sv
// Shared types and constants for the sequential signed divider.
package seq_div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } div_state_t;

   localparam int unsigned DIV_WIDTH = 32;
   localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH);

endpackage

// File: rtl/div_restore_step.sv
// One radix-2 restoring division iteration: shift, trial subtract, restore.
module div_restore_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH:0]   rem,
   input  logic [WIDTH-1:0] dvd,
   input  logic [WIDTH-1:0] dsr,
   output logic [WIDTH:0]   rem_next,
   output logic [WIDTH-2:0] dvd_next,
   output logic             qbit
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;
   logic           rem_msb_unused;

   // The remainder stays below |b| <= 2^(WIDTH-1), so its top bit never carries information.
   assign rem_msb_unused = rem[WIDTH];

   always_comb begin
      shifted  = {rem[WIDTH-1:0], dvd[WIDTH-1]};
      diff     = shifted - {1'b0, dsr};
      qbit     = ~diff[WIDTH];
      rem_next = qbit ? diff : shifted;
      dvd_next = dvd[WIDTH-2:0];
   end

endmodule

// File: rtl/seq_signed_divider.sv
// Multi-cycle signed divider (quotient truncates toward zero, remainder follows dividend).
// Optional: define SEQ_DIV_FAST_PATH_EN to skip CALC when a==0 or b==0.
module seq_signed_divider
   import seq_div_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

   div_state_t       state, state_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic [WIDTH:0]   rem, rem_n;
   logic [WIDTH-1:0] dvd, dvd_n;
   logic [WIDTH-1:0] bmag, bmag_n;
   logic             sign_q, sign_q_n;
   logic             sign_r, sign_r_n;
   logic             dz, dz_n;
   logic             busy_n, done_n, div_by_zero_n;
   logic [WIDTH-1:0] quotient_n, remainder_n;
   logic [WIDTH-1:0] amag_in, bmag_in;

   logic [WIDTH:0]   step_rem;
   logic [WIDTH-2:0] step_dvd;
   logic             step_qbit;

   div_restore_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem),
      .dvd      (dvd),
      .dsr      (bmag),
      .rem_next (step_rem),
      .dvd_next (step_dvd),
      .qbit     (step_qbit)
   );

   // |-2^(WIDTH-1)| wraps to itself, which is exactly 2^(WIDTH-1) read as unsigned.
   assign amag_in = a[WIDTH-1] ? -a : a;
   assign bmag_in = b[WIDTH-1] ? -b : b;

   always_comb begin
      state_n       = state;
      cnt_n         = cnt;
      rem_n         = rem;
      dvd_n         = dvd;
      bmag_n        = bmag;
      sign_q_n      = sign_q;
      sign_r_n      = sign_r;
      dz_n          = dz;
      busy_n        = busy;
      done_n        = 1'b0;
      quotient_n    = quotient;
      remainder_n   = remainder;
      div_by_zero_n = div_by_zero;
      unique case (state)
         IDLE: begin
            if (start) begin
               busy_n   = 1'b1;
               sign_q_n = a[WIDTH-1] ^ b[WIDTH-1];
               sign_r_n = a[WIDTH-1];
               dz_n     = (b == '0);
               bmag_n   = bmag_in;
               cnt_n    = CNT_LOAD;
`ifdef SEQ_DIV_FAST_PATH_EN
               // Preload the final iteration state so FIX yields the same results as CALC would.
               if ((b == '0) || (a == '0)) begin
                  rem_n   = {1'b0, amag_in};
                  dvd_n   = '0;
                  state_n = FIX;
               end else begin
                  rem_n   = '0;
                  dvd_n   = amag_in;
                  state_n = CALC;
               end
`else
               rem_n    = '0;
               dvd_n    = amag_in;
               state_n  = CALC;
`endif
            end
         end
         CALC: begin
            rem_n = step_rem;
            dvd_n = {step_dvd, step_qbit};
            if (cnt == '0) begin
               state_n = FIX;
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         FIX: begin
            quotient_n    = dz ? '1 : (sign_q ? -dvd : dvd);
            remainder_n   = sign_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
            div_by_zero_n = dz;
            done_n        = 1'b1;
            busy_n        = 1'b0;
            state_n       = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         rem         <= '0;
         dvd         <= '0;
         bmag        <= '0;
         sign_q      <= 1'b0;
         sign_r      <= 1'b0;
         dz          <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         rem         <= rem_n;
         dvd         <= dvd_n;
         bmag        <= bmag_n;
         sign_q      <= sign_q_n;
         sign_r      <= sign_r_n;
         dz          <= dz_n;
         busy        <= busy_n;
         done        <= done_n;
         quotient    <= quotient_n;
         remainder   <= remainder_n;
         div_by_zero <= div_by_zero_n;
      end
   end

endmodule

// File: tb/tb_seq_signed_divider.sv
// Self-checking bench for seq_signed_divider: vector table, scoreboard, multi-cycle corner cases.
module tb_seq_signed_divider;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] a, b;
   logic        busy, done, div_by_zero;
   logic [31:0] quotient, remainder;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
      logic        dz;
   } vec_t;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        dz;
   } exp_t;

   exp_t sb[$];

   seq_signed_divider #(.WIDTH(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .a           (a),
      .b           (b),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endfunction

   function automatic int exp_lat(input logic [31:0] va, input logic [31:0] vb);
`ifdef SEQ_DIV_FAST_PATH_EN
      return ((va == 0) || (vb == 0)) ? 2 : 34;
`else
      return 34;
`endif
   endfunction

   task automatic issue(input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] eq, input logic [31:0] er, input logic edz);
      exp_t e;
      a     = va;
      b     = vb;
      start = 1'b1;
      e.q   = eq;
      e.r   = er;
      e.dz  = edz;
      sb.push_back(e);
   endtask

   task automatic compare_out(input string nm);
      exp_t e;
      if (sb.size() == 0) begin
         total++;
         bad++;
         $display("FAIL %s: done with empty scoreboard, got q=%h", nm, quotient);
      end else begin
         e = sb.pop_front();
         chk({nm, "/q"}, quotient, e.q);
         chk({nm, "/r"}, remainder, e.r);
         chk({nm, "/dz"}, {31'd0, div_by_zero}, {31'd0, e.dz});
      end
   endtask

   task automatic wait_done(input int lat, input string nm);
      int n;
      bit got;
      bit busy_ok;
      n       = 0;
      got     = 1'b0;
      busy_ok = 1'b1;
      while (!got && n < 200) begin
         @(negedge clk);
         n++;
         start = 1'b0;
         if (done) begin
            got = 1'b1;
            if (busy) busy_ok = 1'b0;
            compare_out(nm);
            chk({nm, "/lat"}, n, lat);
         end else if (!busy) begin
            busy_ok = 1'b0;
         end
      end
      if (!got) begin
         total++;
         bad++;
         $display("FAIL %s/timeout: no done after %0d cycles, want %0d", nm, n, lat);
      end
      chk({nm, "/busy"}, {31'd0, busy_ok}, 32'd1);
   endtask

   vec_t tbl[16];

   initial begin
      int dones;

      tbl[0]  = '{32'd2000,       32'hFFFFFE0C, 32'hFFFFFFFC, 32'h00000000, 1'b0};
      tbl[1]  = '{32'hFFFFFC19,   32'd10,       32'hFFFFFF9D, 32'hFFFFFFF7, 1'b0};
      tbl[2]  = '{32'hFFFFFFB0,   32'hFFFFFFBF, 32'h00000001, 32'hFFFFFFF1, 1'b0};
      tbl[3]  = '{32'd98765,      32'd0,        32'hFFFFFFFF, 32'h000181CD, 1'b1};
      tbl[4]  = '{32'h80000000,   32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0};
      tbl[5]  = '{32'h7FFFFFFF,   32'd1,        32'h7FFFFFFF, 32'h00000000, 1'b0};
      tbl[6]  = '{32'd7,          32'd2,        32'h00000003, 32'h00000001, 1'b0};
      tbl[7]  = '{32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
      tbl[8]  = '{32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 1'b0};
      tbl[9]  = '{32'd0,          32'd5,        32'h00000000, 32'h00000000, 1'b0};
      tbl[10] = '{32'hFFFFFFFB,   32'd0,        32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1};
      tbl[11] = '{32'h80000000,   32'd1,        32'h80000000, 32'h00000000, 1'b0};
      tbl[12] = '{32'd5,          32'd7,        32'h00000000, 32'h00000005, 1'b0};
      tbl[13] = '{32'h80000000,   32'h80000000, 32'h00000001, 32'h00000000, 1'b0};
      tbl[14] = '{32'd100,        32'h80000000, 32'h00000000, 32'h00000064, 1'b0};
      tbl[15] = '{32'd0,          32'd0,        32'hFFFFFFFF, 32'h00000000, 1'b1};

      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      repeat (2) @(negedge clk);
      chk("reset/busy", {31'd0, busy}, 32'd0);
      chk("reset/done", {31'd0, done}, 32'd0);
      chk("reset/q", quotient, 32'd0);
      chk("reset/r", remainder, 32'd0);
      chk("reset/dz", {31'd0, div_by_zero}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 16; i++) begin
         issue(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dz);
         wait_done(exp_lat(tbl[i].a, tbl[i].b), $sformatf("vec%0d", i));
         repeat (2) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      chk("hold/q", quotient, 32'hFFFFFFFF);
      chk("hold/dz", {31'd0, div_by_zero}, 32'd1);

      // Starts during an ongoing divide must be dropped.
      issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
      dones = 0;
      for (int i = 1; i <= 45; i++) begin
         @(negedge clk);
         if (done) begin
            dones++;
            compare_out("ignore");
            chk("ignore/lat", i, 34);
         end
         start = (i == 5) || (i == 20);
         if (start) begin
            a = 32'h00001234;
            b = 32'd3;
         end
      end
      chk("ignore/dones", dones, 32'd1);

      // Back-to-back: new start in the done cycle.
      issue(32'h7FFFFFFF, 32'd1, 32'h7FFFFFFF, 32'd0, 1'b0);
      wait_done(34, "b2b0");
      issue(32'hFFFFFC19, 32'd10, 32'hFFFFFF9D, 32'hFFFFFFF7, 1'b0);
      wait_done(34, "b2b1");

      // Asynchronous reset in the middle of CALC.
      issue(32'd12345, 32'd7, 32'd1763, 32'd4, 1'b0);
      repeat (17) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst = 1'b1;
      #1;
      chk("abort/busy", {31'd0, busy}, 32'd0);
      chk("abort/done", {31'd0, done}, 32'd0);
      chk("abort/q", quotient, 32'd0);
      chk("abort/r", remainder, 32'd0);
      void'(sb.pop_back());
      @(negedge clk);
      rst = 1'b0;
      dones = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) dones++;
      end
      chk("abort/nodone", dones, 32'd0);
      issue(32'd12345, 32'd7, 32'd1763, 32'd4, 1'b0);
      wait_done(34, "after_abort");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seq_signed_divider.md
Name: seq_signed_divider

Overview:
Multi-cycle 32-bit two's-complement divider. Computes the truncating quotient and remainder of a/b using a radix-2 restoring algorithm, one quotient bit per clock. It is the inverse datapath companion to the team's combinational 32x32 signed multiplier and shares that block's operand conventions (signed a, b). Operands are accepted with a start/busy/done handshake, so the block sits behind the same ALU operand registers as the multiplier.

Parameters:
WIDTH, 32, operand, quotient and remainder width in bits; must be 2 or greater.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request a divide; sampled only when busy=0.
a  input  WIDTH  signed dividend; sampled on the accepting edge.
b  input  WIDTH  signed divisor; sampled on the accepting edge.
busy  output  1  high from the accepting edge until the edge that raises done.
done  output  1  one-cycle pulse; quotient and remainder are valid.
quotient  output  WIDTH  signed quotient, truncated toward zero.
remainder  output  WIDTH  signed remainder; sign follows the dividend.
div_by_zero  output  1  set with done when b==0; holds until the next done.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
- Internal registers: |a|, |b|, partial remainder (WIDTH+1 bits), sign_q = a[MSB]^b[MSB], sign_r = a[MSB].
- States:
  - IDLE: start=1 latches the operands and sign flags, loads counter=WIDTH-1, sets busy=1, moves to CALC.
  - CALC: each cycle shifts the remainder/dividend pair left by 1. A trial subtract of |b| restores the previous remainder if negative, else keeps the result and sets the quotient bit to 1. At counter==0 moves to FIX; otherwise counter decrements. CALC lasts exactly WIDTH cycles.
  - FIX: applies signs (negate quotient if sign_q, negate remainder if sign_r), registers the outputs, asserts done=1 for the next cycle, clears busy, returns to IDLE.
- Latency: done is high in the cycle after the (WIDTH+2)th rising edge counted from the accepting edge, i.e. 34 cycles for WIDTH=32. Throughput is one divide per WIDTH+2 cycles.
- start while busy=1: ignored; no queueing.
- start in the same cycle done=1: accepted, because busy is already 0.
- Outputs hold their last values between done pulses.
- b==0: quotient = all ones (-1), remainder = a, div_by_zero=1. Same latency unless the optional feature is enabled.
- a = -2^(WIDTH-1), b = -1: quotient = -2^(WIDTH-1) (wraps), remainder = 0, no flag.
- Magnitude arithmetic: |-2^(WIDTH-1)| is held as the unsigned value 2^(WIDTH-1), so no extra operand bit is needed. The trial subtract is WIDTH+1 bits wide.
- rst mid-operation: aborts immediately to the reset values; no done pulse is produced.

Optional Feature:
SEQ_DIV_FAST_PATH_EN
- Defined: in IDLE, if b==0 or a==0 the block skips CALC and goes straight to FIX with the special-case results. done then asserts 2 cycles after the accepting edge.
- Undefined: every divide, including b==0 and a==0, takes WIDTH+2 cycles. Results are identical either way; only latency differs.

Decomposition:
- Package seq_div_pkg: state enum (IDLE, CALC, FIX), default WIDTH constant, and a counter width localparam of $clog2(WIDTH).
- Sub-module div_restore_step (combinational): one shift/trial-subtract/restore iteration. Inputs are the partial remainder, the dividend bits and |b|; outputs are the next remainder, next dividend bits and the quotient bit. It is instantiated once inside the top-level FSM.

Test Plan:
- a=2000, b=-500 → quotient=FFFFFFFC, remainder=0, done exactly 34 cycles after start, busy high throughout.
- a=-999, b=10 → quotient=FFFFFF9D (-99), remainder=FFFFFFF7 (-9); a=-80, b=-65 → quotient=1, remainder=FFFFFFF1 (-15).
- a=98765, b=0 → quotient=FFFFFFFF, remainder=000181CD, div_by_zero=1. Latency is 34 cycles without the macro and 2 cycles with SEQ_DIV_FAST_PATH_EN.
- a=80000000, b=FFFFFFFF → quotient=80000000, remainder=0, div_by_zero=0; a=7FFFFFFF, b=1 → quotient=7FFFFFFF.
- start pulsed at cycles 5 and 20 of an ongoing divide → both ignored, exactly one done. A new start in the done cycle is accepted, giving back-to-back results.
- rst asserted at cycle 17 of CALC → busy=0, done=0 and outputs=0 immediately (asynchronous). The next divide after release completes correctly.
